// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style sequencer for the multi-cycle RISC-V core.
// Steps the shared datapath (one ALU, one unified memory port) through
// fetch/decode/execute/memory/writeback for R-type, I-type ALU, LW, SW,
// BEQ and JAL. Variable-latency memory stalls the sequence via mem_ready.
// Optional macro PERF_CNT_EN adds cycle and retired-instruction counters
// (cycle_cnt, instret_cnt, CNT_W bits wide). The default build has no counters.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_2_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  state_e state_q;
  state_e state_d;

  // State register; reset always returns the sequencer to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; reset forces every output low, which aborts any in-flight access.
  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_2_reg  = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    state      = state_q;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_RTYPE:           state_d = S_EXEC_R;
          OP_ITYPE:           state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d    = S_MEM_WR;
        end
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_2_reg  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        pc_src     = 1'b1;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      mem_2_reg  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      state      = 4'd0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q;
  logic [CNT_W-1:0] instret_cnt_d;

  // Counter increments; both wrap naturally at 2^CNT_W.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
    instret_cnt_d = instret_cnt_q + CNT_W'(instr_done);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed, cycle-by-cycle bench for multicycle_ctrl.
// Each cycle the expected control vector is pushed to a scoreboard queue when
// inputs are driven, then popped and compared against the DUT on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ILL = 7'b1110011;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_src;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       mem_2_reg;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;
`ifdef PERF_CNT_EN
  logic [3:0] cycle_cnt;
  logic [3:0] instret_cnt;
`endif

  int errorCount = 0;
  int checkCount = 0;

  logic [18:0] expQueue[$];
  string       tagQueue[$];

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .mem_2_reg  (mem_2_reg),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control vector for a given (externally supplied) state, from the state table.
  function automatic logic [18:0] expVec(input logic r, input logic [3:0] st,
                                         input logic [6:0] op, input logic z,
                                         input logic mr);
    logic pw, ps, irw, iod, mrd, mwr, asa, m2r, rw, done, ill;
    logic [1:0] asb, aop;
    pw = 0; ps = 0; irw = 0; iod = 0; mrd = 0; mwr = 0; asa = 0;
    m2r = 0; rw = 0; done = 0; ill = 0; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1: begin
        asb = 2'b10;
        ill = !(op == OP_R || op == OP_I || op == OP_LW || op == OP_SW ||
                op == OP_BEQ || op == OP_JAL);
      end
      4'd2: begin asa = 1; asb = 2'b00; aop = 2'b10; end
      4'd3: begin asa = 1; asb = 2'b10; end
      4'd4: begin asa = 1; asb = 2'b10; end
      4'd5: begin iod = 1; mrd = 1; end
      4'd6: begin iod = 1; mwr = 1; done = mr; end
      4'd7: begin rw = 1; done = 1; end
      4'd8: begin rw = 1; m2r = 1; done = 1; end
      4'd9: begin asa = 1; aop = 2'b01; ps = 1; pw = z; done = 1; end
      4'd10: begin ps = 1; pw = 1; done = 1; end
      default: ;
    endcase
    if (r) return 19'd0;
    return {pw, ps, irw, iod, mrd, mwr, asa, asb, aop, m2r, rw, done, ill, st};
  endfunction

  // Drive one cycle of inputs and record what the DUT must show during it.
  task automatic applyStimulus(input logic r, input logic [6:0] op, input logic z,
                               input logic mr, input logic [3:0] expState,
                               input string tag);
    rst       = r;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    expQueue.push_back(expVec(r, expState, op, z, mr));
    tagQueue.push_back(tag);
  endtask

  // Pop the oldest expectation and compare it to the DUT outputs.
  task automatic checkOutput();
    logic [18:0] obs;
    logic [18:0] exp;
    string       tag;
    obs = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_src_a,
           alu_src_b, alu_op, mem_2_reg, reg_write, instr_done, illegal_op, state};
    checkCount++;
    if (expQueue.size() == 0) begin
      errorCount++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=<entry>", obs);
      return;
    end
    exp = expQueue.pop_front();
    tag = tagQueue.pop_front();
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full clock cycle: drive after the rising edge, check at the falling edge.
  task automatic runCycle(input logic r, input logic [6:0] op, input logic z,
                          input logic mr, input logic [3:0] expState,
                          input string tag);
    applyStimulus(r, op, z, mr, expState, tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence of instructions, waits, and reset corner cases.
  initial begin
    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;

    runCycle(1, OP_R, 0, 1, 4'd0, "reset_0");
    runCycle(1, OP_R, 0, 1, 4'd0, "reset_1");

    runCycle(0, OP_R, 0, 1, 4'd0, "rtype_fetch");
    runCycle(0, OP_R, 0, 1, 4'd1, "rtype_decode");
    runCycle(0, OP_R, 0, 1, 4'd2, "rtype_exec");
    runCycle(0, OP_R, 0, 1, 4'd7, "rtype_wb");

    runCycle(0, OP_I, 0, 1, 4'd0, "itype_fetch");
    runCycle(0, OP_I, 0, 0, 4'd1, "itype_decode_noready");
    runCycle(0, OP_I, 0, 0, 4'd3, "itype_exec_noready");
    runCycle(0, OP_I, 0, 0, 4'd7, "itype_wb_noready");

    runCycle(0, OP_LW, 0, 1, 4'd0, "lw_fetch");
    runCycle(0, OP_LW, 0, 1, 4'd1, "lw_decode");
    runCycle(0, OP_LW, 0, 1, 4'd4, "lw_addr");
    runCycle(0, OP_LW, 0, 0, 4'd5, "lw_rd_wait1");
    runCycle(0, OP_LW, 0, 0, 4'd5, "lw_rd_wait2");
    runCycle(0, OP_LW, 0, 1, 4'd5, "lw_rd_done");
    runCycle(0, OP_LW, 0, 1, 4'd8, "lw_wb");

    runCycle(0, OP_BEQ, 1, 1, 4'd0, "beq_taken_fetch");
    runCycle(0, OP_BEQ, 1, 1, 4'd1, "beq_taken_decode");
    runCycle(0, OP_BEQ, 1, 1, 4'd9, "beq_taken_branch");
    runCycle(0, OP_BEQ, 0, 1, 4'd0, "beq_not_fetch");
    runCycle(0, OP_BEQ, 0, 1, 4'd1, "beq_not_decode");
    runCycle(0, OP_BEQ, 0, 1, 4'd9, "beq_not_branch");

    runCycle(0, OP_JAL, 0, 0, 4'd0, "jal_fetch_wait1");
    runCycle(0, OP_JAL, 0, 0, 4'd0, "jal_fetch_wait2");
    runCycle(0, OP_JAL, 0, 1, 4'd0, "jal_fetch_done");
    runCycle(0, OP_JAL, 0, 1, 4'd1, "jal_decode");
    runCycle(0, OP_JAL, 0, 1, 4'd10, "jal_jump");

    runCycle(0, OP_ILL, 0, 1, 4'd0, "illegal_fetch");
    runCycle(0, OP_ILL, 0, 1, 4'd1, "illegal_decode");

    runCycle(0, OP_SW, 0, 1, 4'd0, "sw_fetch");
    runCycle(0, OP_SW, 0, 1, 4'd1, "sw_decode");
    runCycle(0, OP_SW, 0, 1, 4'd4, "sw_addr");
    runCycle(0, OP_SW, 0, 0, 4'd6, "sw_wr_wait");
    runCycle(0, OP_SW, 0, 1, 4'd6, "sw_wr_done");

    runCycle(0, OP_SW, 0, 1, 4'd0, "abort_fetch");
    runCycle(0, OP_SW, 0, 1, 4'd1, "abort_decode");
    runCycle(0, OP_SW, 0, 1, 4'd4, "abort_addr");
    runCycle(0, OP_SW, 0, 0, 4'd6, "abort_wr_wait");
    runCycle(1, OP_SW, 0, 0, 4'd6, "abort_rst_in_memwr");
    runCycle(0, OP_SW, 0, 0, 4'd0, "abort_after_reset_fetch");

    runCycle(1, OP_SW, 0, 1, 4'd0, "perf_reset");
    for (int n = 0; n < 5; n++) begin
      runCycle(0, OP_SW, 0, 1, 4'd0, "perf_sw_fetch");
      runCycle(0, OP_SW, 0, 1, 4'd1, "perf_sw_decode");
      runCycle(0, OP_SW, 0, 1, 4'd4, "perf_sw_addr");
      runCycle(0, OP_SW, 0, 1, 4'd6, "perf_sw_wr");
    end
`ifdef PERF_CNT_EN
    checkCount++;
    assert (cycle_cnt === 4'd4) else begin
      errorCount++;
      $error("[TB] FAIL cycle_cnt_wrap observed=%0d expected=%0d", cycle_cnt, 4);
    end
    checkCount++;
    assert (instret_cnt === 4'd5) else begin
      errorCount++;
      $error("[TB] FAIL instret_cnt observed=%0d expected=%0d", instret_cnt, 5);
    end
`endif

    checkCount++;
    assert (expQueue.size() == 0) else begin
      errorCount++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQueue.size());
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RISC-V core. It replaces single-cycle control decode with a Moore-style FSM that steps the shared datapath (one ALU, one unified memory port) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It supports R-type, I-type ALU, LW, SW, BEQ and JAL. It handshakes with the memory via mem_ready so that variable-latency memory stalls the sequence.

Parameters:
CNT_W, 32, width of performance counters (used only with PERF_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  7  instruction[6:0] from the instruction register; stable from DECODE until return to FETCH
zero  in  1  ALU zero flag, current cycle
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC register load enable
pc_src  out  1  0 = ALU result, 1 = ALUOut register
ir_write  out  1  instruction register load enable
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
alu_src_a  out  1  0 = old PC, 1 = rs1
alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
alu_op  out  2  00 = add, 01 = sub, 10 = R-type funct decode
mem_2_reg  out  1  register write-back data select: 1 = memory data register
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
state  out  4  current state encoding (debug)

Behaviour:
- State register is 4 bit. Encodings:
  - FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5
  - MEM_WR = 6, WB_ALU = 7, WB_MEM = 8, BRANCH = 9, JUMP = 10
  - Codes 11-15 go to FETCH on the next edge with all outputs 0.
- Outputs are combinational from state, except where mem_ready or zero is noted. Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 0.
  - If mem_ready = 1: ir_write = 1, pc_write = 1, next state DECODE. Otherwise stay in FETCH with no enables.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 10, alu_op = 00; the datapath latches the branch/jump target into ALUOut.
  - Next state by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; 1101111 -> JUMP.
  - Any other opcode: illegal_op = 1, instr_done = 0, next state FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10; next WB_ALU.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 00; next WB_ALU.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00; next MEM_RD for opcode 0000011, MEM_WR for opcode 0100011.
- MEM_RD: i_or_d = 1, mem_read = 1; on mem_ready go to WB_MEM, otherwise hold.
- MEM_WR: i_or_d = 1, mem_write = 1; on mem_ready: instr_done = 1, next FETCH; otherwise hold.
- WB_ALU: reg_write = 1, mem_2_reg = 0, instr_done = 1; next FETCH.
- WB_MEM: reg_write = 1, mem_2_reg = 1, instr_done = 1; next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 1, pc_write = zero, instr_done = 1; next FETCH.
- JUMP: pc_src = 1, pc_write = 1, instr_done = 1; no link write; next FETCH.
- Latency with zero-wait memory (mem_ready = 1 on first request cycle), FETCH to FETCH:
  - BEQ and JAL: 3 cycles.
  - R-type, I-type, SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR. mem_read/mem_write stay asserted and stable through wait cycles.
- Reset:
  - With rst = 1 at a rising edge, state becomes FETCH.
  - While rst = 1, every output is forced to 0 combinationally, including write enables and pulses.
  - Reset during MEM_WR or any wait state aborts the access. There is no partial retire and no instr_done.
  - First fetch request occurs in the first cycle with rst = 0.

Optional Feature:
PERF_CNT_EN
- Defined:
  - Adds outputs cycle_cnt [CNT_W-1:0] and instret_cnt [CNT_W-1:0], both synchronously cleared by rst.
  - cycle_cnt increments every cycle with rst = 0.
  - instret_cnt increments on each instr_done.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then R-type 0110011, mem_ready = 1 always -> state sequence 0,1,2,7,0; reg_write = 1 only in cycle 4; instr_done pulses once.
- LW 0000011 with mem_ready low for 2 cycles in MEM_RD -> state 5 held 3 cycles with mem_read = 1 and i_or_d = 1; then WB_MEM with mem_2_reg = 1; total 7 cycles.
- BEQ with zero = 1, then BEQ with zero = 0 -> pc_write = 1 and pc_src = 1 in BRANCH for the first; pc_write = 0 for the second; both 3 cycles with instr_done.
- Opcode 1110011 -> illegal_op pulses in DECODE; returns to FETCH; no reg_write, mem_write or instr_done.
- rst asserted while in MEM_WR with mem_ready = 0 -> mem_write drops the same cycle; state = 0 after the edge; no instr_done.
- PERF_CNT_EN defined, CNT_W = 4; run 5 SW instructions (20 cycles) -> instret_cnt = 5; cycle_cnt wraps to 4.
